// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential 8-digit BCD to 28-bit binary converter. One digit is folded into
// the accumulator per clock (acc = acc*10 + digit, MSD first), so a conversion
// takes 8 cycles in CONV followed by a one-cycle done pulse in IDLE.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   conversion request, sampled only in IDLE
//   bcd_in   in  32   8 BCD digits, [31:28] = 10^7 ... [3:0] = 10^0
//   busy     out  1   high while the FSM is in CONV
//   done     out  1   one-cycle pulse: bin_out / err have just been updated
//   bin_out  out 28   binary result, held between done pulses
//   err      out  1   invalid-digit flag, held between done pulses
//
// Build option:
//   BCDTOBIN_ERRCHK_EN  when defined, any digit > 9 makes the conversion
//                       report err=1 with bin_out=0. When undefined, err is
//                       tied low and digits 10..15 are accumulated at face value.
// -----------------------------------------------------------------------------
module bcd_to_bin_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bcd_in,
    output logic        busy,
    output logic        done,
    output logic [27:0] bin_out,
    output logic        err
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] shreg;
    logic [27:0] acc;
    logic [2:0]  cnt;

    logic [3:0]  digit;
    logic [27:0] acc_next;
    logic        last;

    assign digit    = shreg[31:28];
    // Multiply by 10 as x*8 + x*2; 28 bits cannot overflow (max 166,666,665).
    assign acc_next = (acc << 3) + (acc << 1) + {24'd0, digit};
    assign last     = (state == CONV) && (cnt == 3'd7);
    assign busy     = (state == CONV);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first, so no path leaves next_state unassigned
        // (which would infer a latch).
        next_state = state;
        case (state)
            IDLE: if (start) next_state = CONV;
            CONV: if (last)  next_state = IDLE;
            default:         next_state = IDLE;
        endcase
    end

`ifdef BCDTOBIN_ERRCHK_EN
    logic err_latch;
    logic err_next;

    // The final digit is checked in the same edge that publishes the result.
    assign err_next = err_latch | (digit > 4'd9);
`endif

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            bin_out   <= '0;
`ifdef BCDTOBIN_ERRCHK_EN
            err_latch <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    shreg     <= bcd_in;
                    acc       <= '0;
                    cnt       <= '0;
`ifdef BCDTOBIN_ERRCHK_EN
                    err_latch <= 1'b0;
`endif
                end
            end else begin
                acc   <= acc_next;
                shreg <= {shreg[27:0], 4'd0};
                cnt   <= cnt + 3'd1;
`ifdef BCDTOBIN_ERRCHK_EN
                err_latch <= err_next;
`endif
                if (last) begin
                    done <= 1'b1;
`ifdef BCDTOBIN_ERRCHK_EN
                    bin_out <= err_next ? 28'd0 : acc_next;
                    err     <= err_next;
`else
                    bin_out <= acc_next;
`endif
                end
            end
        end
    end

`ifndef BCDTOBIN_ERRCHK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//
// Directed, table-driven bench for bcd_to_bin_seq. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] bcd_in;
    logic        busy;
    logic        done;
    logic [27:0] bin_out;
    logic        err;

    int total = 0;
    int bad   = 0;

`ifdef BCDTOBIN_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    bcd_to_bin_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bcd;
        logic [27:0] bin;
        logic        err;
        bit          bump;   // re-pulse start at conversion cycles 2 and 5
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts one conversion from a falling edge in IDLE and watches 12 samples.
    // Sample n is taken at the falling edge after rising edge k+n-1, so the
    // done pulse (after edge k+8) should appear at n=9 and busy at n=1..8.
    task automatic run_conv(input string name, input logic [31:0] bcd,
                            input logic [27:0] exp_bin, input logic exp_err,
                            input bit bump);
        int          busy_cnt = 0;
        int          done_cnt = 0;
        int          done_at  = 0;
        bit          stable   = 1'b1;
        logic [27:0] prev_bin = bin_out;
        logic        prev_err = err;
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bcd_in = ~bcd;     // must not affect the captured value
        for (int n = 1; n <= 12; n++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            if (n <= 8 && (bin_out !== prev_bin || err !== prev_err)) stable = 1'b0;
            start = bump && (n == 2 || n == 5);
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " done_count"}, done_cnt, 1);
        check({name, " done_cycle"}, done_at, 9);
        check({name, " busy_cycles"}, busy_cnt, 8);
        check({name, " held_during_conv"}, {31'd0, stable}, 1);
        check({name, " bin_out"}, {4'd0, bin_out}, {4'd0, exp_bin});
        check({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 28'd0,         1'b0, 1'b0};
        vecs[1] = '{32'h9999_9999, 28'd99999999,  1'b0, 1'b0};
        vecs[2] = '{32'h1234_5678, 28'hBC614E,    1'b0, 1'b1};
        vecs[3] = '{32'h1234_567A, ERRCHK ? 28'd0 : 28'hBC6150, ERRCHK, 1'b0};
        vecs[4] = '{32'h0000_0042, 28'd42,        1'b0, 1'b0};
        vecs[5] = '{32'h1000_0000, 28'd10000000,  1'b0, 1'b0};
        vecs[6] = '{32'h0000_0001, 28'd1,         1'b0, 1'b0};
        vecs[7] = '{32'h9000_0009, 28'd90000009,  1'b0, 1'b0};
        vecs[8] = '{32'hFFFF_FFFF, ERRCHK ? 28'd0 : 28'd166666665, ERRCHK, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset bin_out", {4'd0, bin_out}, 0);
        check("reset err", {31'd0, err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].bump);

        // Start held high: second conversion accepted at edge k+9 with its own bcd_in.
        begin
            int d1 = 0;
            int d2 = 0;
            start  = 1'b1;
            bcd_in = 32'h0000_0123;
            @(posedge clk);
            for (int n = 1; n <= 18; n++) begin
                @(negedge clk);
                if (n == 9) begin
                    d1 = done;
                    check("b2b first bin_out", {4'd0, bin_out}, 32'd123);
                    bcd_in = 32'h0007_0000;   // captured at edge k+9
                end
                if (n == 10) check("b2b re-accept busy", {31'd0, busy}, 1);
                if (n == 18) d2 = done;
            end
            start = 1'b0;
            check("b2b first done", d1, 1);
            check("b2b second done", d2, 1);
            check("b2b second bin_out", {4'd0, bin_out}, 32'd70000);
            @(negedge clk);
        end

        // Reset in the middle of a conversion: outputs clear at once, no done.
        begin
            int dseen = 0;
            start  = 1'b1;
            bcd_in = 32'h0000_0042;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midreset busy", {31'd0, busy}, 0);
            check("midreset done", {31'd0, done}, 0);
            check("midreset bin_out", {4'd0, bin_out}, 0);
            check("midreset err", {31'd0, err}, 0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                if (done) dseen++;
            end
            check("midreset no_done", dseen, 0);
            run_conv("after_reset", 32'h0000_0042, 28'd42, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
